// File: rtl/video_pattern_gen.sv
// video_pattern_gen
//   Generates test frames of H_ACTIVE x V_ACTIVE pixels as a valid/ready
//   stream. Frame generation starts when en is high and only stops on a
//   frame boundary. The pattern is chosen by mode, which is latched at each
//   frame start.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-high
//   en         : keep generating frames while high
//   mode       : pattern select (0 index, 1 x, 2 y, 3 checkerboard)
//   down_valid : stream valid (registered, independent of down_ready)
//   down_ready : stream ready from the downstream sink
//   down_data  : pixel value
//   down_tlast : last pixel of a line
//   down_tuser : first pixel of a frame
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
//   busy       : high while a frame is being generated
module video_pattern_gen #(
    parameter int D_WIDTH  = 8,
    parameter int H_ACTIVE = 8,
    parameter int V_ACTIVE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    output logic               down_valid,
    input  logic               down_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_tlast,
    output logic               down_tuser,
    output logic               frame_done,
    output logic               busy
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    // y*H_ACTIVE+x never exceeds H_ACTIVE*V_ACTIVE-1 < 2^(XW+YW)
    localparam int IW = XW + YW;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q;
    logic [XW-1:0]        x_q;
    logic [YW-1:0]        y_q;
    logic [1:0]           mode_q;
    logic                 valid_q;
    logic [D_WIDTH-1:0]   data_q;
    logic                 tlast_q;
    logic                 tuser_q;
    logic                 frame_done_q;
    logic                 busy_q;

    logic [XW-1:0]        x_d;
    logic [YW-1:0]        y_d;
    logic                 xfer;
    logic                 last_x;
    logic                 last_y;

    // Pixel value for a coordinate and pattern; values are zero-extended
    // before truncation so any D_WIDTH works.
    function automatic logic [D_WIDTH-1:0] pixel(input logic [XW-1:0] px,
                                                 input logic [YW-1:0] py,
                                                 input logic [1:0]    m);
        logic [IW-1:0]         idx;
        logic [IW+D_WIDTH-1:0] idx_w;
        logic [XW+D_WIDTH-1:0] x_w;
        logic [YW+D_WIDTH-1:0] y_w;
        logic [D_WIDTH-1:0]    res;
        idx   = IW'(py) * IW'(H_ACTIVE) + IW'(px);
        idx_w = {{D_WIDTH{1'b0}}, idx};
        x_w   = {{D_WIDTH{1'b0}}, px};
        y_w   = {{D_WIDTH{1'b0}}, py};
        case (m)
            2'd0:    res = idx_w[D_WIDTH-1:0];
            2'd1:    res = x_w[D_WIDTH-1:0];
            2'd2:    res = y_w[D_WIDTH-1:0];
            default: res = {D_WIDTH{px[0] ^ py[0]}};
        endcase
        return res;
    endfunction

    always_comb begin
        xfer   = valid_q & down_ready;
        last_x = (x_q == X_LAST);
        last_y = (y_q == Y_LAST);
        x_d    = last_x ? '0 : x_q + 1'b1;
        y_d    = y_q;
        if (last_x) begin
            y_d = last_y ? '0 : y_q + 1'b1;
        end
    end

    // Outputs are registered from the coordinate being presented, so they
    // hold naturally while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            mode_q       <= 2'd0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        x_q     <= '0;
                        y_q     <= '0;
                        mode_q  <= mode;
                        valid_q <= 1'b1;
                        data_q  <= pixel('0, '0, mode);
                        tlast_q <= 1'b0;  // H_ACTIVE >= 2, so x=0 is never last
                        tuser_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (last_x && last_y) begin
                            frame_done_q <= 1'b1;
                            x_q          <= '0;
                            y_q          <= '0;
                            if (en) begin
                                // Back-to-back frame: no idle bubble.
                                mode_q  <= mode;
                                data_q  <= pixel('0, '0, mode);
                                tlast_q <= 1'b0;
                                tuser_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                valid_q <= 1'b0;
                                data_q  <= '0;
                                tlast_q <= 1'b0;
                                tuser_q <= 1'b0;
                            end
                        end else begin
                            // (0,0) is only reached at a frame wrap, so tuser drops.
                            x_q     <= x_d;
                            y_q     <= y_d;
                            data_q  <= pixel(x_d, y_d, mode_q);
                            tlast_q <= (x_d == X_LAST);
                            tuser_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign down_valid = valid_q;
    assign down_data  = data_q;
    assign down_tlast = tlast_q;
    assign down_tuser = tuser_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
module tb_video_pattern_gen;

    localparam int H = 8;
    localparam int V = 4;
    localparam int N = H * V;
    localparam int D = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         down_valid;
    logic         down_ready;
    logic [D-1:0] down_data;
    logic         down_tlast;
    logic         down_tuser;
    logic         frame_done;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    int beats = 0;
    int fd_seen = 0;

    video_pattern_gen #(.D_WIDTH(D), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_tlast (down_tlast),
        .down_tuser (down_tuser),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the frame is a list of N pixels; track whether a
    // frame is running, which pixel number is on offer and the frame's mode.
    bit m_run  = 1'b0;
    int m_p    = 0;
    int m_mode = 0;
    bit m_fd   = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run  <= 1'b0;
            m_p    <= 0;
            m_mode <= 0;
            m_fd   <= 1'b0;
        end else begin
            m_fd <= 1'b0;
            if (!m_run) begin
                if (en) begin
                    m_run  <= 1'b1;
                    m_p    <= 0;
                    m_mode <= int'(mode);
                end
            end else if (down_ready) begin
                if (m_p == N - 1) begin
                    m_fd <= 1'b1;
                    if (en) begin
                        m_p    <= 0;
                        m_mode <= int'(mode);
                    end else begin
                        m_run <= 1'b0;
                        m_p   <= 0;
                    end
                end else begin
                    m_p <= m_p + 1;
                end
            end
        end
    end

    // Packed view: {valid, busy, tuser, tlast, frame_done, data}
    function automatic logic [12:0] model_out();
        int x;
        int y;
        logic [7:0] d;
        if (!m_run) return {4'b0000, m_fd, 8'h00};
        x = m_p % H;
        y = m_p / H;
        case (m_mode)
            0:       d = 8'(m_p % 256);
            1:       d = 8'(x % 256);
            2:       d = 8'(y % 256);
            default: d = ((x + y) % 2 == 1) ? 8'hFF : 8'h00;
        endcase
        return {1'b1, 1'b1, (m_p == 0), (x == H - 1), m_fd, d};
    endfunction

    function automatic logic [12:0] dut_out();
        return {down_valid, busy, down_tuser, down_tlast, frame_done, down_data};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: inputs are already driven; compare against the model at the
    // following falling edge.
    task automatic step(input string name);
        bit xf;
        xf = down_valid && down_ready && !rst;
        @(negedge clk);
        if (xf) beats++;
        if (frame_done) fd_seen++;
        check(name, 32'(dut_out()), 32'(model_out()));
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 200 && down_valid; c++) step(name);
        if (down_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got valid=1 want valid=0 within 200 cycles", name);
        end
        step(name);
    endtask

    typedef struct {
        bit       en;
        bit [1:0] mode;
        bit       rdy;
        bit       v;
        bit       b;
        bit       tu;
        bit       tl;
        bit       fd;
        bit [7:0] d;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Checkerboard start with the sink alternating ready, en and mode
        // changed mid-frame.
        tbl[0]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF};
        tbl[2]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF};
        tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF};
        tbl[11] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF};
        tbl[12] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        rst = 1'b0;
        en = 1'b0;
        mode = 2'd0;
        down_ready = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset", 32'(dut_out()), 32'd0);
        rst = 1'b0;
        step("idle");

        // Table-driven vectors
        foreach (tbl[i]) begin
            en = tbl[i].en;
            mode = tbl[i].mode;
            down_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("tbl%0d", i), 32'(dut_out()),
                  32'({tbl[i].v, tbl[i].b, tbl[i].tu, tbl[i].tl, tbl[i].fd, tbl[i].d}));
        end
        down_ready = 1'b1;
        drain("tbl_drain");

        // One frame of index pattern, en only for the first cycle
        beats = 0; fd_seen = 0;
        en = 1'b1; mode = 2'd0; down_ready = 1'b1;
        step("f_idx");
        en = 1'b0;
        drain("f_idx");
        check("f_idx_beats", 32'(beats), 32'd32);
        check("f_idx_fd", 32'(fd_seen), 32'd1);

        // Long stall on the first pixel
        beats = 0; fd_seen = 0;
        en = 1'b1; mode = 2'd0; down_ready = 1'b0;
        step("stall");
        en = 1'b0;
        repeat (20) step("stall");
        check("stall_first", 32'({down_valid, down_tuser, down_data}), 32'({1'b1, 1'b1, 8'h00}));
        down_ready = 1'b1;
        drain("stall");
        check("stall_beats", 32'(beats), 32'd32);

        // Two back-to-back frames, mode changed mid-frame
        beats = 0; fd_seen = 0;
        en = 1'b1; mode = 2'd1; down_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            step("two_frames");
            if (beats == 10) mode = 2'd2;
            if (beats >= 32) en = 1'b0;
            if (!down_valid && beats > 0) break;
        end
        check("two_frames_beats", 32'(beats), 32'd64);
        check("two_frames_fd", 32'(fd_seen), 32'd2);

        // en dropped at beat 5 does not truncate the frame
        beats = 0; fd_seen = 0;
        en = 1'b1; mode = 2'd2; down_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            step("en_drop");
            if (beats == 5) en = 1'b0;
            if (!down_valid && beats > 0) break;
        end
        check("en_drop_beats", 32'(beats), 32'd32);
        check("en_drop_busy", 32'(busy), 32'd0);

        // Reset in the middle of a stalled frame
        beats = 0;
        en = 1'b1; mode = 2'd0; down_ready = 1'b1;
        for (int c = 0; c < 100 && beats < 12; c++) step("pre_rst");
        down_ready = 1'b0;
        step("pre_rst");
        fd_seen = 0;
        #2 rst = 1'b1;
        #1 check("rst_now", 32'(dut_out()), 32'd0);
        down_ready = 1'b1;
        @(negedge clk);
        check("rst_hold", 32'(dut_out()), 32'd0);
        rst = 1'b0;
        beats = 0;
        step("post_rst");
        check("post_rst_first", 32'({down_valid, down_tuser, down_data}), 32'({1'b1, 1'b1, 8'h00}));
        en = 1'b0;
        drain("post_rst");
        check("post_rst_beats", 32'(beats), 32'd32);
        check("post_rst_fd", 32'(fd_seen), 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            en = ($urandom_range(0, 7) != 0);
            mode = 2'($urandom);
            down_ready = ($urandom_range(0, 2) != 0);
            step("rand");
        end
        rst = 1'b0;
        en = 1'b0;
        down_ready = 1'b1;
        drain("rand_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameter D_WIDTH, default 8: pixel data width in bits.
REQ-002 Parameter H_ACTIVE, default 8: pixels per line; legal range 2..4096, even.
REQ-003 Parameter V_ACTIVE, default 4: lines per frame; legal range 2..4096, even.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 en  input  1  level; generate frames while high.
REQ-007 mode  input  2  pattern select, sampled only at frame start.
REQ-008 down_valid  output  1  stream valid.
REQ-009 down_ready  input  1  stream ready from the downscaler.
REQ-010 down_data  output  D_WIDTH  pixel value.
REQ-011 down_tlast  output  1  high on the last pixel of each line.
REQ-012 down_tuser  output  1  high on the first pixel of each frame only.
REQ-013 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
REQ-014 busy  output  1  high while in state RUN.

Function
REQ-015 FSM states SHALL be IDLE and RUN only.
REQ-016 IDLE->RUN when en=1.
- Load x=0, y=0.
- Latch mode into mode_q.
- down_valid asserts the cycle after en is sampled high (1-cycle latency).
REQ-017 Transfer = down_valid & down_ready on a rising edge; x/y advance only on a transfer.
REQ-018 Under backpressure:
- Once down_valid is high, it SHALL stay high.
- down_data, down_tlast and down_tuser SHALL stay constant until the transfer.
REQ-019 On a transfer:
- x<H_ACTIVE-1: x increments.
- Otherwise: x=0, and y increments.
- y wraps to 0 after V_ACTIVE-1.
REQ-020 down_tlast = (x==H_ACTIVE-1).
REQ-021 down_tuser = (x==0 && y==0).
REQ-022 Pattern by mode_q:
- 0: pixel index y*H_ACTIVE+x, truncated to D_WIDTH.
- 1: x truncated to D_WIDTH.
- 2: y truncated to D_WIDTH.
- 3: all-ones if x[0]^y[0], else 0.
REQ-023 Index arithmetic SHALL be wide enough for H_ACTIVE*V_ACTIVE-1 before truncation.
REQ-024 Last-pixel transfer (x=H_ACTIVE-1, y=V_ACTIVE-1):
- frame_done pulses high for exactly the next cycle.
- If en=1: stay in RUN, re-latch mode, and present the next frame's first pixel (tuser=1) in the next cycle with no bubble.
- If en=0: go to IDLE, and down_valid deasserts in the next cycle.
REQ-025 en deasserted mid-frame SHALL NOT truncate the frame; generation stops only at a frame boundary.
REQ-026 mode changes mid-frame SHALL have no effect until the next frame start.
REQ-027 In IDLE:
- down_valid=0 and busy=0.
- down_data, down_tlast and down_tuser SHALL hold 0.
REQ-028 down_valid SHALL NOT depend combinationally on down_ready.

Reset
REQ-029 rst high SHALL immediately force:
- state=IDLE, x=0, y=0, mode_q=0.
- down_valid=0, down_data=0, down_tlast=0, down_tuser=0.
- frame_done=0, busy=0.
REQ-030 rst mid-frame SHALL abandon the frame with no frame_done pulse.
REQ-031 After rst release with en=1, the next frame SHALL start at x=0, y=0 with tuser=1.
REQ-032 No output SHALL glitch to a non-reset value while rst is high, regardless of en or down_ready.

Verification
REQ-033 Default parameters, mode=0, en=1 one frame then 0, down_ready=1 -> 32 beats with data 0..31:
- tuser on beat 0 only.
- tlast on beats 7, 15, 23, 31.
- frame_done one cycle after beat 31.
- down_valid=0 after that.
REQ-034 mode=3, down_ready toggling 1/0 each cycle -> data sequence 00,FF,00,FF... on line 0 and FF,00,... on line 1; payload held stable on every stalled cycle; 32 transfers total.
REQ-035 en held 1 for two frames with mode=1 then mode=2 switched at beat 10 -> frame 1 all x values 0..7 repeating; frame 2 data equals y (0,0,...,3); no idle cycle between beat 31 and the next tuser.
REQ-036 en dropped at beat 5 -> the full 32 beats still issue, then IDLE and busy=0.
REQ-037 rst asserted at beat 12 with down_valid=1 and down_ready=0 -> same cycle down_valid=0 and busy=0; no frame_done; after release with en=1 the first beat has data 0 and tuser=1.
REQ-038 down_ready=0 for 20 cycles at beat 0 -> down_valid stays 1 with data 0 and tuser=1 throughout; the sequence resumes intact.
